// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding, default width and counter helper for the serial adder
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FIN   = ST_FIN
    } state_t;

    // Ripple incrementer so the adder cell stays the only arithmetic in the block.
    function automatic logic [4:0] inc5(input logic [4:0] v);
        logic [4:0] r;
        logic       cy;
        cy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r[i] = v[i] ^ cy;
            cy   = v[i] & cy;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for the serial adder
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             COUT;

    modport master (
        output START, A, B, CIN,
        input  BUSY, DONE, S, COUT
    );

    modport slave (
        input  START, A, B, CIN,
        output BUSY, DONE, S, COUT
    );

endinterface

// File: rtl/FullAdder.sv
// rtl/FullAdder.sv - one-bit full adder cell
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder feeding one FullAdder cell an operand bit pair per clock
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    serial_adder_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] s_q;
    logic             c;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             last;
    logic             unused_ps0;

    FullAdder u_fa (
        .A    (ra[0]),
        .B    (rb[0]),
        .Cin  (c),
        .S    (fa_s),
        .Cout (fa_co)
    );

    // The LSB of ps is shifted out on every step and never observed.
    assign unused_ps0 = ps[0];

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        last     = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (bus.START) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                if (bus.START) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            ps     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                ra  <= bus.A;
                rb  <= bus.B;
                c   <= bus.CIN;
                cnt <= '0;
                ps  <= '0;
            end else if (state == SHIFT) begin
                ra  <= {1'b0, ra[WIDTH-1:1]};
                rb  <= {1'b0, rb[WIDTH-1:1]};
                ps  <= {fa_s, ps[WIDTH-1:1]};
                c   <= fa_co;
                cnt <= CW'(inc5(5'(cnt)));
                // Result registers only move on the final step, so S/COUT hold during SHIFT.
                if (last) begin
                    s_q    <= {fa_s, ps[WIDTH-1:1]};
                    cout_q <= fa_co;
                end
            end
        end
    end

    assign bus.BUSY = (state == SHIFT);
    assign bus.DONE = (state == FIN);
    assign bus.S    = s_q;
    assign bus.COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed vector bench for serial_adder at WIDTH=8
module tb_serial_adder;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_s;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one addition in the current cycle, returns after DONE is seen or the bound expires.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           output int lat, output int nbusy, output bit held);
        logic [7:0] s0;
        logic       c0;
        s0    = bus.S;
        c0    = bus.COUT;
        held  = 1'b1;
        nbusy = 0;
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.CIN   = ci;
        tick();
        bus.START = 1'b0;
        bus.A     = ~a;
        bus.B     = 8'h33;
        bus.CIN   = ~ci;
        lat = 1;
        while (!bus.DONE && lat < 20) begin
            if (bus.BUSY) nbusy++;
            if (bus.S !== s0 || bus.COUT !== c0) held = 1'b0;
            tick();
            lat++;
        end
    endtask

    initial begin
        int         lat;
        int         nbusy;
        bit         held;
        int         ndone;
        int         idx;
        logic [7:0] ha[30];
        logic [7:0] hb[30];
        logic       hc[30];
        logic [8:0] sum;
        int         exp_done[3];

        pass_cnt  = 0;
        total_cnt = 0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        exp_done[0] = 9;
        exp_done[1] = 18;
        exp_done[2] = 27;

        rst = 1'b1;
        bus.START = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        bus.CIN   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_done", 32'(bus.DONE), 32'd0);
        check("reset_s",    32'(bus.S),    32'd0);
        check("reset_cout", 32'(bus.COUT), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat, nbusy, held);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
            check($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 32'd8);
            check($sformatf("vec%0d_held", i), 32'(held), 32'd1);
            check($sformatf("vec%0d_s", i), 32'(bus.S), 32'(vecs[i].exp_s));
            check($sformatf("vec%0d_cout", i), 32'(bus.COUT), 32'(vecs[i].exp_cout));
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'({bus.DONE, bus.BUSY}), 32'd0);
        end

        // START held high with operands changing every cycle.
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            ha[k] = 8'(k * 37 + 11);
            hb[k] = 8'(k * 91 + 200);
            hc[k] = k[0];
            bus.START = 1'b1;
            bus.A     = ha[k];
            bus.B     = hb[k];
            bus.CIN   = hc[k];
            if (bus.DONE) begin
                if (ndone < 3) begin
                    check($sformatf("b2b%0d_cycle", ndone), 32'(k), 32'(exp_done[ndone]));
                    idx = (k >= 9) ? k - 9 : 0;
                    sum = {1'b0, ha[idx]} + {1'b0, hb[idx]} + 9'(hc[idx]);
                    check($sformatf("b2b%0d_s", ndone), 32'(bus.S), 32'(sum[7:0]));
                    check($sformatf("b2b%0d_cout", ndone), 32'(bus.COUT), 32'(sum[8]));
                end
                ndone++;
            end
            tick();
        end
        bus.START = 1'b0;
        check("b2b_done_count", 32'(ndone), 32'd3);
        lat = 0;
        while (!bus.DONE && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_drain_done", 32'(bus.DONE), 32'd1);
        tick();

        run_add(8'h5A, 8'h3C, 1'b0, lat, nbusy, held);
        check("pre_rst_s", 32'(bus.S), 32'h96);
        tick();

        // Reset in cycle 4 of an addition.
        bus.START = 1'b1;
        bus.A     = 8'h11;
        bus.B     = 8'h22;
        bus.CIN   = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy_before_rst", 32'(bus.BUSY), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_done", 32'(bus.DONE), 32'd0);
        check("mid_rst_s",    32'(bus.S),    32'd0);
        check("mid_rst_cout", 32'(bus.COUT), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.DONE || bus.BUSY) ndone++;
            tick();
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        run_add(8'h12, 8'h34, 1'b0, lat, nbusy, held);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_s",    32'(bus.S),    32'h46);
        check("post_rst_cout", 32'(bus.COUT), 32'd0);
        tick();

        // START together with RST is lost.
        rst = 1'b1;
        bus.START = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'hFF;
        tick();
        rst = 1'b0;
        bus.START = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.DONE || bus.BUSY) ndone++;
            tick();
        end
        check("start_rst_idle", 32'(ndone), 32'd0);
        check("start_rst_s", 32'(bus.S), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the existing one-bit `FullAdder` cell. It is the sequential consumer of that cell: it feeds the cell one operand bit pair per clock and registers the carry it produces. It shifts the sum bits into a result register. It presents a start/busy/done handshake to the controlling logic. It trades WIDTH cycles of latency for a single adder cell.

## Interface
Parameters:
- `WIDTH`, default 8, operand and sum width in bits; legal range is 2 to 32.

Ports:
- `CLK`, input, 1 bit, the single clock. All state updates on the rising edge.
- `RST`, input, 1 bit, synchronous reset, active-high.
- `START`, input, 1 bit, request to begin an addition. Sampled only when `BUSY`=0.
- `A`, input, WIDTH bits, operand A. Sampled in the cycle in which `START` is accepted.
- `B`, input, WIDTH bits, operand B. Sampled at the same time as `A`.
- `CIN`, input, 1 bit, carry-in. Sampled at the same time as `A`.
- `BUSY`, output, 1 bit, high while an addition is in progress.
- `DONE`, output, 1 bit, one-cycle pulse indicating that `S` and `COUT` are valid.
- `S`, output, WIDTH bits, registered sum. Holds its value until the next completion.
- `COUT`, output, 1 bit, registered carry-out. Holds its value until the next completion.

## Operation
- FSM states:
  - IDLE (reset state).
  - SHIFT.
  - FIN.
- IDLE, or FIN, with `START`=1:
  - load `A` and `B` into the operand shift registers `ra` and `rb`;
  - set the carry register `c` <= `CIN`;
  - set the bit counter `cnt` <= 0;
  - clear the partial-sum register `ps`;
  - go to SHIFT.
- IDLE with `START`=0: stay in IDLE.
- FIN with `START`=0: go to IDLE.
- SHIFT, every cycle:
  - `FullAdder` inputs: A=`ra[0]`, B=`rb[0]`, Cin=`c`.
  - `ra` and `rb` shift right by one bit; the vacated MSB is filled with 0.
  - `ps` <= {`FullAdder` sum bit, `ps[WIDTH-1:1]`}. The LSB is therefore produced first and lands at bit 0 after WIDTH shifts.
  - `c` <= `FullAdder` carry-out.
  - `cnt` <= `cnt`+1.
- SHIFT, when `cnt`==WIDTH-1 (the last shift):
  - `S` <= the final `ps` value, including this cycle's sum bit;
  - `COUT` <= this cycle's carry-out;
  - go to FIN.
- Output decode:
  - `BUSY` = (state==SHIFT).
  - `DONE` = (state==FIN).
- Width of `cnt`: $clog2(WIDTH) bits.
- Arithmetic: {`COUT`,`S`} = `A` + `B` + `CIN`, modulo 2^(WIDTH+1). The result is exact, with no saturation.
- `START` while `BUSY`=1 is ignored. The operation in progress is not disturbed and the operand inputs are not sampled.
- `START` in the FIN cycle is accepted. This allows back-to-back additions with no idle cycle.
- `S` and `COUT` do not change during SHIFT; they keep the previous result.
- Reset, in any state including mid-SHIFT: all registers clear and the state goes to IDLE. After reset `BUSY`=0, `DONE`=0, `S`=0 and `COUT`=0. The partial result is discarded.
- `START` in the same cycle as `RST`=1: reset wins and the start is lost.

## Timing
- Cycle 0: `START` is accepted. On the edge that ends cycle 0, the state becomes SHIFT.
- Cycles 1 to WIDTH: SHIFT, with `BUSY`=1.
- Cycle WIDTH+1: FIN, with `DONE`=1, and `S` and `COUT` valid.
- Latency from `START` to `DONE` is WIDTH+1 cycles.
- Throughput is one addition per WIDTH+1 cycles when `START` is held high.
- `S` and `COUT` update on the same edge on which `DONE` rises.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Shared package `serial_adder_pkg` contains:
  - the state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1 and `ST_FIN`=2'd2;
  - `DEF_WIDTH`=8.
- Sub-module: one instance of the existing `FullAdder`. It is the only arithmetic in the block; no `+` operator is used.
- The remaining logic is the FSM, `cnt`, `ra`, `rb`, `c`, `ps`, `S` and `COUT`.

## Test plan
- WIDTH=8, `A`=0x5A, `B`=0x3C, `CIN`=0, `START` pulsed in cycle 0 -> `BUSY` high in cycles 1 to 8; `DONE` high only in cycle 9; `S`=0x96, `COUT`=0.
- WIDTH=8, 0xFF+0x01 with `CIN`=0 -> `S`=0x00, `COUT`=1. Separately, 0xFF+0xFF with `CIN`=1 -> `S`=0xFF, `COUT`=1.
- `START` held high for 30 cycles with operands changing every cycle -> completions in cycles 9, 18 and 27. Each result matches the operands sampled in cycles 0, 9 and 18 respectively. The operand changes during SHIFT are ignored.
- After a result of 0x96 completes, a new `START` with 0x01+0x01 -> `S` stays 0x96 during cycles 1 to 8 of the new operation, then becomes 0x02 when `DONE` is asserted.
- `RST` asserted for one cycle in cycle 4 of an addition -> the next cycle shows `BUSY`=0, `DONE`=0, `S`=0 and `COUT`=0, and no `DONE` pulse follows. A new `START` afterwards completes correctly.
- `START` and `RST` both high in the same cycle -> the block stays in IDLE and `BUSY` stays 0.
